// File: rtl/sha_uart_pkg.sv
// Shared types and constants for the SHA-256 digest to UART sequencer.
package sha_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_SHA,
        SEND,
        DONE
    } state_t;

    localparam int DIGEST_W = 256;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/sha_hex_encoder.sv
// Combinational nibble to uppercase ASCII hex character.
module sha_hex_encoder (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/sha_digest_uart_seq.sv
// Launches one SHA-256 run, captures the digest and streams it to the UART
// byte interface as uppercase hex or raw bytes, optionally followed by CR LF.
module sha_digest_uart_seq
    import sha_uart_pkg::*;
#(
    parameter bit          HEX_MODE       = 1'b1,
    parameter bit          APPEND_CRLF    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    output logic                o_sha_start,
    input  logic                i_sha_done,
    input  logic [DIGEST_W-1:0] i_sha_digest,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    localparam int PAYLOAD = HEX_MODE ? 64 : 32;
    localparam int N       = PAYLOAD + (APPEND_CRLF ? 2 : 0);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [6:0]    LAST_IDX     = 7'(N - 1);
    localparam logic [6:0]    PAYLOAD_IDX  = 7'(PAYLOAD);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [DIGEST_W-1:0] digest_q;
    logic [6:0]          idx;
    logic [TW-1:0]       tcnt;

    logic [DIGEST_W-1:0] nib_shift;
    logic [DIGEST_W-1:0] byte_shift;
    logic [3:0]          nibble;
    logic [7:0]          hex_char;
    logic [7:0]          raw_byte;
    logic [7:0]          byte_sel;

    // Left-shifting by the index brings the selected nibble/byte to the MSBs.
    assign nib_shift  = digest_q << {idx, 2'b00};
    assign byte_shift = digest_q << {idx, 3'b000};
    assign nibble     = nib_shift[DIGEST_W-1 -: 4];
    assign raw_byte   = byte_shift[DIGEST_W-1 -: 8];

    sha_hex_encoder u_hex_encoder (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        byte_sel = HEX_MODE ? hex_char : raw_byte;
        if (idx == PAYLOAD_IDX) begin
            byte_sel = CHAR_CR;
        end else if (idx > PAYLOAD_IDX) begin
            byte_sel = CHAR_LF;
        end
    end

    // Gated so the data bus reads zero whenever nothing is being offered.
    assign o_tx_data = o_tx_valid ? byte_sel : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            digest_q    <= '0;
            idx         <= '0;
            tcnt        <= '0;
            o_sha_start <= 1'b0;
            o_tx_valid  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state       <= START;
                        o_error     <= 1'b0;
                        o_sha_start <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                START: begin
                    o_sha_start <= 1'b0;
                    tcnt        <= '0;
                    state       <= WAIT_SHA;
                end
                WAIT_SHA: begin
                    // Aborts after TIMEOUT_CYCLES full WAIT_SHA cycles without done.
                    if (i_sha_done) begin
                        digest_q   <= i_sha_digest;
                        idx        <= '0;
                        o_tx_valid <= 1'b1;
                        state      <= SEND;
                    end else if (tcnt == TIMEOUT_LAST) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                SEND: begin
                    if (i_tx_ready) begin
                        if (idx == LAST_IDX) begin
                            o_tx_valid <= 1'b0;
                            o_done     <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_digest_uart_seq.sv
// Directed bench: a hex+CRLF instance and a raw instance share all inputs.
module tb_sha_digest_uart_seq;

    typedef struct {
        logic [255:0] digest;
        int           stall_at;
        int           stall_len;
        bit           extra_start;
        logic [31:0]  hex_first4;
        logic [31:0]  hex_last4;
        logic [15:0]  raw_first2;
        logic [15:0]  raw_last2;
    } run_vec_t;

    localparam logic [255:0] D_ABC =
        256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
    localparam logic [255:0] D_PAT = {8{32'h0F1E2D3C}};
    localparam logic [255:0] D_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic         i_sha_done;
    logic [255:0] i_sha_digest;
    logic         i_tx_ready;

    logic       a_sha_start, a_tx_valid, a_busy, a_done, a_error;
    logic [7:0] a_tx_data;
    logic       b_sha_start, b_tx_valid, b_busy, b_done, b_error;
    logic [7:0] b_tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sha_digest_uart_seq #(.HEX_MODE(1'b1), .APPEND_CRLF(1'b1), .TIMEOUT_CYCLES(16)) u_hex (
        .clk(clk), .rst(rst), .i_start(i_start), .o_sha_start(a_sha_start),
        .i_sha_done(i_sha_done), .i_sha_digest(i_sha_digest),
        .o_tx_data(a_tx_data), .o_tx_valid(a_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(a_busy), .o_done(a_done), .o_error(a_error)
    );

    sha_digest_uart_seq #(.HEX_MODE(1'b0), .APPEND_CRLF(1'b0), .TIMEOUT_CYCLES(16)) u_raw (
        .clk(clk), .rst(rst), .i_start(i_start), .o_sha_start(b_sha_start),
        .i_sha_done(i_sha_done), .i_sha_digest(i_sha_digest),
        .o_tx_data(b_tx_data), .o_tx_valid(b_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(b_busy), .o_done(b_done), .o_error(b_error)
    );

    // Cumulative monitors sampled on the falling edge.
    int         cyc = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         a_hs_cyc[$];
    int         a_starts = 0, a_dones = 0, a_valids = 0, a_done_cyc = 0;
    int         b_starts = 0, b_dones = 0, b_valids = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_tx_valid && i_tx_ready) begin
            qa.push_back(a_tx_data);
            a_hs_cyc.push_back(cyc);
        end
        if (b_tx_valid && i_tx_ready) qb.push_back(b_tx_data);
        if (a_sha_start) a_starts <= a_starts + 1;
        if (b_sha_start) b_starts <= b_starts + 1;
        if (a_done) begin
            a_dones    <= a_dones + 1;
            a_done_cyc <= cyc;
        end
        if (b_done) b_dones <= b_dones + 1;
        if (a_tx_valid) a_valids <= a_valids + 1;
        if (b_tx_valid) b_valids <= b_valids + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] exp_byte(input logic [255:0] d, input bit hex, input int i);
        string        hx;
        logic [255:0] t;
        logic [3:0]   nib;
        hx = "0123456789ABCDEF";
        if (hex) begin
            if (i == 64) return 8'h0D;
            if (i == 65) return 8'h0A;
            t   = d >> (252 - 4 * i);
            nib = t[3:0];
            return hx[nib];
        end
        t = d >> (248 - 8 * i);
        return t[7:0];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_a_tx_data"}, a_tx_data, 0);
        check({tag, "_a_tx_valid"}, a_tx_valid, 0);
        check({tag, "_a_busy"}, a_busy, 0);
        check({tag, "_a_done"}, a_done, 0);
        check({tag, "_a_sha_start"}, a_sha_start, 0);
        check({tag, "_a_error"}, a_error, 0);
        check({tag, "_b_tx_valid"}, b_tx_valid, 0);
        check({tag, "_b_busy"}, b_busy, 0);
    endtask

    task automatic run(input run_vec_t v, input string tag);
        int qa0, qb0, as0, ad0, bs0, bd0, k;
        qa0 = qa.size();
        qb0 = qb.size();
        as0 = a_starts; ad0 = a_dones; bs0 = b_starts; bd0 = b_dones;
        i_tx_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        if (v.extra_start) begin
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        i_sha_digest = v.digest;
        i_sha_done   = 1'b1;
        tick();
        i_sha_done   = 1'b0;
        i_sha_digest = '0;
        if (v.extra_start) begin
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        if (v.stall_len > 0) begin
            for (k = 0; k < 200 && (qa.size() - qa0) < v.stall_at; k++) tick();
            check({tag, "_stall_reached"}, qa.size() - qa0, v.stall_at);
            i_tx_ready = 1'b0;
            for (int s = 0; s < v.stall_len; s++) begin
                @(negedge clk);
                check({tag, "_stall_valid"}, a_tx_valid, 1);
                check({tag, "_stall_data"}, a_tx_data, exp_byte(v.digest, 1'b1, v.stall_at));
                tick();
            end
            i_tx_ready = 1'b1;
        end
        for (k = 0; k < 300 && (a_dones == ad0 || b_dones == bd0); k++) tick();
        repeat (3) tick();

        check({tag, "_hex_count"}, qa.size() - qa0, 66);
        check({tag, "_raw_count"}, qb.size() - qb0, 32);
        if (qa.size() - qa0 == 66) begin
            for (int i = 0; i < 66; i++)
                check({tag, $sformatf("_hex_byte%0d", i)}, qa[qa0 + i], exp_byte(v.digest, 1'b1, i));
            check({tag, "_hex_first4"}, {qa[qa0], qa[qa0+1], qa[qa0+2], qa[qa0+3]}, v.hex_first4);
            check({tag, "_hex_last4"}, {qa[qa0+62], qa[qa0+63], qa[qa0+64], qa[qa0+65]}, v.hex_last4);
            check({tag, "_hex_span"}, a_hs_cyc[qa0 + 65] - a_hs_cyc[qa0], 65 + v.stall_len);
            check({tag, "_done_timing"}, a_done_cyc, a_hs_cyc[qa0 + 65] + 1);
        end
        if (qb.size() - qb0 == 32) begin
            for (int i = 0; i < 32; i++)
                check({tag, $sformatf("_raw_byte%0d", i)}, qb[qb0 + i], exp_byte(v.digest, 1'b0, i));
            check({tag, "_raw_first2"}, {qb[qb0], qb[qb0+1]}, v.raw_first2);
            check({tag, "_raw_last2"}, {qb[qb0+30], qb[qb0+31]}, v.raw_last2);
        end
        check({tag, "_a_starts"}, a_starts - as0, 1);
        check({tag, "_a_dones"}, a_dones - ad0, 1);
        check({tag, "_b_starts"}, b_starts - bs0, 1);
        check({tag, "_b_dones"}, b_dones - bd0, 1);
        check({tag, "_a_idle_busy"}, a_busy, 0);
    endtask

    run_vec_t vecs[4];

    initial begin
        int n, v0, d0, q0, k;
        vecs[0] = '{D_ABC,   0,  0, 1'b0, 32'h42413738, 32'h41440D0A, 16'hBA78, 16'h15AD};
        vecs[1] = '{D_ABC,  10,  5, 1'b1, 32'h42413738, 32'h41440D0A, 16'hBA78, 16'h15AD};
        vecs[2] = '{D_PAT,   3,  2, 1'b0, 32'h30463145, 32'h33430D0A, 16'h0F1E, 16'h2D3C};
        vecs[3] = '{D_EMPTY, 0,  0, 1'b1, 32'h45334230, 32'h35350D0A, 16'hE3B0, 16'hB855};

        rst = 1'b1;
        i_start = 1'b0;
        i_sha_done = 1'b0;
        i_sha_digest = '0;
        i_tx_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        for (int r = 0; r < 4; r++) run(vecs[r], $sformatf("run%0d", r));

        // Timeout: done never arrives.
        v0 = a_valids;
        d0 = a_dones;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        @(negedge clk);
        check("to_sha_start", a_sha_start, 1);
        for (n = 1; n < 40; n++) begin
            @(negedge clk);
            if (a_error) break;
        end
        check("to_latency", n, 17);
        check("to_b_error", b_error, 1);
        check("to_busy", a_busy, 0);
        check("to_no_valid", a_valids - v0, 0);
        check("to_no_done", a_dones - d0, 0);
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        @(negedge clk);
        check("to_error_cleared", a_error, 0);
        check("to_restart_busy", a_busy, 1);
        for (k = 0; k < 40 && !a_error; k++) tick();
        check("to_error_again", a_error, 1);
        tick();

        // Reset after 10 accepted bytes.
        q0 = qa.size();
        i_tx_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_sha_digest = D_ABC;
        i_sha_done = 1'b1;
        tick();
        i_sha_done = 1'b0;
        for (k = 0; k < 100 && (qa.size() - q0) < 10; k++) tick();
        check("mid_reached10", qa.size() - q0, 10);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        tick();
        rst = 1'b0;
        tick();
        run(vecs[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sha_digest_uart_seq.md
Name: sha_digest_uart_seq

Overview:
Top-level sequencer between the SHA-256 core and the UART transmitter. On a start request it launches one SHA-256 computation and waits for the core's done. It then captures the 256-bit digest and streams it to the UART byte interface, as uppercase ASCII hex or raw bytes, optionally followed by CR LF. Status is reported on busy/done/error, and the board-level done pin is driven from o_done.

Parameters:
HEX_MODE, 1, 1 = 64 ASCII hex chars (upper nibble first); 0 = 32 raw bytes.
APPEND_CRLF, 1, 1 = send 0x0D then 0x0A after the digest bytes.
TIMEOUT_CYCLES, 1048576, max cycles to wait for i_sha_done before aborting; must be >= 1.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
i_start  input  1  request one hash-and-transmit run; sampled only in IDLE
o_sha_start  output  1  one-cycle start pulse to the SHA core
i_sha_done  input  1  SHA core completion; digest valid in the same cycle
i_sha_digest  input  256  digest; bits [255:248] are the first byte
o_tx_data  output  8  byte to UART transmitter
o_tx_valid  output  1  o_tx_data valid
i_tx_ready  input  1  UART accepts the byte when o_tx_valid and i_tx_ready are both 1
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse after the last byte is accepted
o_error  output  1  sticky timeout flag; cleared by the next accepted i_start

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0, the digest register is 0, and all counters are 0.
- Total bytes per run N = (HEX_MODE ? 64 : 32) + (APPEND_CRLF ? 2 : 0).
- IDLE:
  - i_start = 1 moves to START next cycle and clears o_error.
  - i_start is ignored in all other states; there is no queueing.
- START: o_sha_start = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT_SHA.
- WAIT_SHA:
  - i_sha_done = 1 latches i_sha_digest and clears byte index idx. Go to SEND.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES, set o_error and go to IDLE without transmitting and without an o_done pulse.
  - i_sha_done is ignored in every other state, including the START cycle.
- SEND:
  - o_tx_valid = 1 from the first SEND cycle, i.e. the cycle after digest capture.
  - o_tx_data is a registered/combinational function of idx and the digest register, and is stable while o_tx_valid = 1 and i_tx_ready = 0.
  - On handshake: if idx = N-1, go to DONE; otherwise idx increments and the next byte is presented in the following cycle. This gives at most 1 byte per cycle when i_tx_ready is held high.
- Byte mapping:
  - Hex mode, idx < 64: nibble digest[255-4*idx -: 4]. Values 0–9 map to 0x30–0x39; values A–F map to 0x41–0x46.
  - Raw mode, idx < 32: byte digest[255-8*idx -: 8].
  - CRLF indices: 0x0D, then 0x0A.
- DONE: o_done = 1 for one cycle, o_tx_valid = 0, then go to IDLE. o_busy is still high in DONE.
- idx width is 7 bits and never wraps past N-1.
- Reset mid-run: outputs drop immediately and the in-flight byte is abandoned; the UART must reset alongside. The next run restarts from byte 0.

Decomposition:
- Package sha_uart_pkg holds:
  - the state enum (IDLE, START, WAIT_SHA, SEND, DONE);
  - ASCII constants CHAR_CR = 8'h0D and CHAR_LF = 8'h0A;
  - DIGEST_W = 256.
- One sub-module, sha_hex_encoder: combinational 4-bit nibble to 8-bit uppercase ASCII. It is instantiated once, fed by the nibble mux.

Test Plan:
- Digest of "abc" (BA7816BF…F20015AD), HEX_MODE=1, CRLF=1, i_tx_ready tied 1 -> exactly 66 bytes are sent on consecutive cycles:
  - first bytes 0x42 0x41 0x37 0x38;
  - last bytes 0x41 0x44 0x0D 0x0A;
  - o_done pulses once, 1 cycle after the last handshake;
  - o_sha_start pulses exactly once.
- Backpressure: drop i_tx_ready for 5 cycles at byte idx 10 -> o_tx_data stays constant and o_tx_valid stays high through the stall. No byte is lost or duplicated, and the total is still 66.
- Raw mode (HEX_MODE=0, APPEND_CRLF=0) on the same digest -> 32 bytes, first 0xBA 0x78, last 0x15 0xAD.
- Timeout with TIMEOUT_CYCLES=16 and i_sha_done never asserted -> o_error rises 16 cycles after START. State returns to IDLE with no o_tx_valid and no o_done. A subsequent i_start clears o_error.
- i_start pulsed during WAIT_SHA and during SEND -> ignored: a single o_sha_start per run and a single o_done.
- Assert rst after 10 accepted bytes -> all outputs are 0 in the same cycle. After release, a new run sends from byte 0 (0x42 first).
